// File: rtl/billiard_turn_controller.sv
// billiard_turn_controller: game-flow FSM for the billiard table (turns, scores, fouls, shot timer, black-ball outcome)
module billiard_turn_controller #(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_BALLS   = 7,
    parameter int SCORE_W     = 4,
    parameter int SHOT_FRAMES = 600,
    parameter int FOUL_LIMIT  = 3,
    localparam int PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
    localparam int TW = $clog2(SHOT_FRAMES + 1),
    localparam int FW = $clog2(FOUL_LIMIT + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       startN,
    input  logic                       hardModeN,
    input  logic                       whiteBallMove,
    input  logic                       playBallHoleCollision,
    input  logic                       whiteHoleCollision,
    input  logic                       blackHoleCollision,
    input  logic                       endOfRoll,
    input  logic                       startOfFrame,
    output logic                       idleState,
    output logic                       init0,
    output logic                       initPlayBalls,
    output logic                       hitEnable,
    output logic                       drawSight,
    output logic                       startOfTurn,
    output logic                       whiteBallin,
    output logic                       drawPortals,
    output logic                       gameOver,
    output logic                       hardMode,
    output logic [PW-1:0]              currentPlayer,
    output logic [PW-1:0]              winner,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
    output logic [NUM_PLAYERS*FW-1:0]  fouls,
    output logic [TW-1:0]              shotTimer
);
    localparam int PKW = $clog2(NUM_BALLS + 1);

    typedef enum logic [2:0] {IDLE, INIT, AIM, ROLL, RESPOT, TURN_END, GAME_OVER} state_t;

    state_t           state;
    logic [PKW-1:0]   pocketed;
    logic             potted;
    logic             scratch;
    logic             foul;
    logic             released;
    logic             sot;
    logic [SCORE_W-1:0] cur_score;
    logic [FW-1:0]    foul_inc;
    logic [PW-1:0]    nxt;
    logic [PKW-1:0]   pk_next;
    logic             shooter_wins;

    assign cur_score    = scores[currentPlayer*SCORE_W +: SCORE_W];
    assign foul_inc     = fouls[currentPlayer*FW +: FW] + 1'b1;
    assign nxt          = (currentPlayer == PW'(NUM_PLAYERS - 1)) ? '0 : currentPlayer + 1'b1;
    assign pk_next      = (playBallHoleCollision && pocketed != PKW'(NUM_BALLS)) ? pocketed + 1'b1 : pocketed;
    assign shooter_wins = (pk_next == PKW'(NUM_BALLS)) && !whiteHoleCollision && !scratch;

    assign idleState     = state == IDLE;
    assign init0         = state == INIT || state == RESPOT;
    assign initPlayBalls = state == INIT;
    assign hitEnable     = state == AIM;
    assign drawSight     = state == AIM;
    assign startOfTurn   = state == AIM && sot;
    assign whiteBallin   = state == RESPOT;
    assign drawPortals   = state == ROLL && hardMode;
    assign gameOver      = state == GAME_OVER;

    // game sequencing together with all score, foul, timer and turn bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            hardMode      <= 1'b0;
            currentPlayer <= '0;
            winner        <= '0;
            scores        <= '0;
            fouls         <= '0;
            shotTimer     <= '0;
            pocketed      <= '0;
            potted        <= 1'b0;
            scratch       <= 1'b0;
            foul          <= 1'b0;
            released      <= 1'b0;
            sot           <= 1'b0;
        end else begin
            case (state)
                IDLE: if (!hardModeN || !startN) begin
                    state         <= INIT;
                    hardMode      <= !hardModeN;
                    scores        <= '0;
                    fouls         <= '0;
                    pocketed      <= '0;
                    currentPlayer <= '0;
                    winner        <= '0;
                end
                INIT: begin
                    state     <= AIM;
                    sot       <= 1'b1;
                    shotTimer <= '0;
                end
                AIM: begin
                    sot <= 1'b0;
                    if (whiteBallMove) begin
                        state   <= ROLL;
                        potted  <= 1'b0;
                        scratch <= 1'b0;
                    end else if (shotTimer == TW'(SHOT_FRAMES)) begin
                        state <= TURN_END;
                        foul  <= 1'b1;
                    end else if (startOfFrame) begin
                        shotTimer <= shotTimer + 1'b1;
                    end
                end
                ROLL: begin
                    if (playBallHoleCollision) begin
                        if (cur_score != '1) scores[currentPlayer*SCORE_W +: SCORE_W] <= cur_score + 1'b1;
                        pocketed <= pk_next;
                        potted   <= 1'b1;
                    end
                    if (blackHoleCollision) begin
                        state    <= GAME_OVER;
                        released <= 1'b0;
                        winner   <= shooter_wins ? currentPlayer : nxt;
                    end else if (whiteHoleCollision) begin
                        scratch <= 1'b1;
                        state   <= RESPOT;
                    end else if (endOfRoll) begin
                        if (potted || playBallHoleCollision) begin
                            state     <= AIM;
                            shotTimer <= '0;
                        end else begin
                            state <= TURN_END;
                            foul  <= 1'b0;
                        end
                    end
                end
                RESPOT: begin
                    state <= TURN_END;
                    foul  <= 1'b1;
                end
                TURN_END: begin
                    if (foul) fouls[currentPlayer*FW +: FW] <= foul_inc;
                    else fouls[currentPlayer*FW +: FW] <= '0;
                    if (foul && foul_inc == FW'(FOUL_LIMIT)) begin
                        state    <= GAME_OVER;
                        released <= 1'b0;
                        winner   <= nxt;
                    end else begin
                        currentPlayer <= nxt;
                        state         <= AIM;
                        sot           <= 1'b1;
                        shotTimer     <= '0;
                    end
                end
                GAME_OVER: begin
                    if (startN) released <= 1'b1;
                    else if (released) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_billiard_turn_controller.sv
// tb_billiard_turn_controller: randomized game play checked cycle by cycle against a rule-level model
module tb_billiard_turn_controller;
    localparam int NP = 2, NB = 7, SW = 4, SF = 600, FLIM = 3;
    localparam int PW = 1, TW = 10, FW = 2;
    localparam int M_IDLE = 0, M_INIT = 1, M_AIM = 2, M_ROLL = 3, M_RESPOT = 4, M_TEND = 5, M_OVER = 6;

    logic clk = 1'b0;
    logic reset, startN, hardModeN, whiteBallMove, playBallHoleCollision;
    logic whiteHoleCollision, blackHoleCollision, endOfRoll, startOfFrame;
    logic idleState, init0, initPlayBalls, hitEnable, drawSight, startOfTurn;
    logic whiteBallin, drawPortals, gameOver, hardMode;
    logic [PW-1:0] currentPlayer, winner;
    logic [NP*SW-1:0] scores;
    logic [NP*FW-1:0] fouls;
    logic [TW-1:0] shotTimer;

    billiard_turn_controller #(
        .NUM_PLAYERS(NP), .NUM_BALLS(NB), .SCORE_W(SW), .SHOT_FRAMES(SF), .FOUL_LIMIT(FLIM)
    ) dut (
        .clk(clk), .reset(reset), .startN(startN), .hardModeN(hardModeN),
        .whiteBallMove(whiteBallMove), .playBallHoleCollision(playBallHoleCollision),
        .whiteHoleCollision(whiteHoleCollision), .blackHoleCollision(blackHoleCollision),
        .endOfRoll(endOfRoll), .startOfFrame(startOfFrame),
        .idleState(idleState), .init0(init0), .initPlayBalls(initPlayBalls),
        .hitEnable(hitEnable), .drawSight(drawSight), .startOfTurn(startOfTurn),
        .whiteBallin(whiteBallin), .drawPortals(drawPortals), .gameOver(gameOver),
        .hardMode(hardMode), .currentPlayer(currentPlayer), .winner(winner),
        .scores(scores), .fouls(fouls), .shotTimer(shotTimer)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    int ph, cp, win, tmr, pk, tgt;
    int sc[NP];
    int fl[NP];
    bit hm, pot, scr, rel, sot, foulp;

    function automatic int min_i(input int a, input int b);
        return a < b ? a : b;
    endfunction

    task automatic model_step();
        if (reset) begin
            ph = M_IDLE; hm = 0; cp = 0; win = 0; tmr = 0; pk = 0;
            pot = 0; scr = 0; rel = 0; sot = 0; foulp = 0;
            foreach (sc[p]) begin sc[p] = 0; fl[p] = 0; end
            return;
        end
        case (ph)
            M_IDLE: if (!hardModeN || !startN) begin
                ph = M_INIT; hm = !hardModeN; cp = 0; win = 0; pk = 0;
                foreach (sc[p]) begin sc[p] = 0; fl[p] = 0; end
            end
            M_INIT: begin ph = M_AIM; sot = 1; tmr = 0; end
            M_AIM: begin
                sot = 0;
                if (whiteBallMove) begin ph = M_ROLL; pot = 0; scr = 0; end
                else if (tmr == SF) begin ph = M_TEND; foulp = 1; end
                else if (startOfFrame) tmr++;
            end
            M_ROLL: begin
                if (playBallHoleCollision) begin
                    sc[cp] = min_i(sc[cp] + 1, (1 << SW) - 1);
                    pk = min_i(pk + 1, NB);
                    pot = 1;
                end
                if (blackHoleCollision) begin
                    ph = M_OVER; rel = 0;
                    win = (pk == NB && !whiteHoleCollision && !scr) ? cp : (cp + 1) % NP;
                end else if (whiteHoleCollision) begin
                    scr = 1; ph = M_RESPOT;
                end else if (endOfRoll) begin
                    if (pot) begin ph = M_AIM; tmr = 0; end
                    else begin ph = M_TEND; foulp = 0; end
                end
            end
            M_RESPOT: begin ph = M_TEND; foulp = 1; end
            M_TEND: begin
                fl[cp] = foulp ? fl[cp] + 1 : 0;
                if (fl[cp] == FLIM) begin
                    ph = M_OVER; rel = 0; win = (cp + 1) % NP;
                end else begin
                    cp = (cp + 1) % NP; ph = M_AIM; sot = 1; tmr = 0;
                end
            end
            default: begin
                if (startN) rel = 1;
                else if (rel) ph = M_IDLE;
            end
        endcase
    endtask

    task automatic drive(input int cyc);
        reset = (cyc < 2) || ($urandom_range(0, 3999) == 0);
        startN = (ph == M_OVER) ? ($urandom_range(0, 2) != 0) :
                 (ph == M_IDLE) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
        hardModeN = $urandom_range(0, 7) != 0;
        if (ph != M_AIM) begin
            case ($urandom_range(0, 19))
                0, 1:    tgt = -1;
                2:       tgt = SF - 1;
                3:       tgt = SF;
                default: tgt = $urandom_range(0, 30);
            endcase
        end
        whiteBallMove = (ph == M_AIM) ? (tgt >= 0 && tmr >= tgt) : ($urandom_range(0, 9) == 0);
        startOfFrame = $urandom_range(0, 3) != 0;
        playBallHoleCollision = $urandom_range(0, 5) == 0;
        blackHoleCollision = $urandom_range(0, (pk == NB) ? 9 : 149) == 0;
        whiteHoleCollision = blackHoleCollision ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
        endOfRoll = $urandom_range(0, 14) == 0;
    endtask

    task automatic compare();
        logic [9:0] es;
        logic [NP*SW-1:0] esc;
        logic [NP*FW-1:0] efl;
        es = {ph == M_IDLE, ph == M_INIT || ph == M_RESPOT, ph == M_INIT, ph == M_AIM, ph == M_AIM,
              ph == M_AIM && sot, ph == M_RESPOT, ph == M_ROLL && hm, ph == M_OVER, hm};
        for (int p = 0; p < NP; p++) begin
            esc[p*SW +: SW] = SW'(sc[p]);
            efl[p*FW +: FW] = FW'(fl[p]);
        end
        check("strobes", 32'({idleState, init0, initPlayBalls, hitEnable, drawSight, startOfTurn,
                              whiteBallin, drawPortals, gameOver, hardMode}), 32'(es));
        check("currentPlayer", 32'(currentPlayer), 32'(cp));
        check("winner", 32'(winner), 32'(win));
        check("scores", 32'(scores), 32'(esc));
        check("fouls", 32'(fouls), 32'(efl));
        check("shotTimer", 32'(shotTimer), 32'(tmr));
    endtask

    initial begin
        reset = 1'b1; startN = 1'b1; hardModeN = 1'b1; whiteBallMove = 1'b0;
        playBallHoleCollision = 1'b0; whiteHoleCollision = 1'b0; blackHoleCollision = 1'b0;
        endOfRoll = 1'b0; startOfFrame = 1'b0;
        ph = M_IDLE; tgt = 0; pk = 0; tmr = 0;
        for (int cyc = 0; cyc < 60000; cyc++) begin
            @(negedge clk);
            drive(cyc);
            model_step();
            @(posedge clk);
            #1;
            compare();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/billiard_turn_controller.md
# billiard_turn_controller

Multi-player game-flow controller for the billiard table. It sequences idle → rack → aim → roll, and rotates turns across `NUM_PLAYERS`. It keeps per-player scores and consecutive-foul counts, enforces an aiming timeout counted in video frames, and decides win or loss on the black ball. It sits between the collision/physics blocks, which supply event pulses, and the drawing/ball-init blocks, which consume its state strobes and scores.

## Interface
- `NUM_PLAYERS`, 2: number of players, ≥2; `PW = max(1,$clog2(NUM_PLAYERS))`.
- `NUM_BALLS`, 7: play balls that must be pocketed before the black.
- `SCORE_W`, 4: per-player score width.
- `SHOT_FRAMES`, 600: `startOfFrame` pulses allowed in aim before a timeout foul; `TW = $clog2(SHOT_FRAMES+1)`.
- `FOUL_LIMIT`, 3: consecutive fouls that lose the game; `FW = $clog2(FOUL_LIMIT+1)`.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `startN` in 1: start button, active-low level.
- `hardModeN` in 1: hard-mode start button, active-low level.
- `whiteBallMove` in 1: cue ball struck, pulse.
- `playBallHoleCollision` in 1: one play ball pocketed, one-cycle pulse per ball.
- `whiteHoleCollision` in 1: cue ball pocketed.
- `blackHoleCollision` in 1: black ball pocketed.
- `endOfRoll` in 1: all balls at rest.
- `startOfFrame` in 1: one pulse per video frame.
- `idleState`, `init0`, `initPlayBalls`, `hitEnable`, `drawSight`, `startOfTurn`, `whiteBallin`, `drawPortals`, `gameOver` out 1 each: state strobes.
- `hardMode` out 1: latched mode.
- `currentPlayer` out PW: player whose turn it is.
- `winner` out PW: valid while `gameOver`.
- `scores` out NUM_PLAYERS*SCORE_W: player p at `[p*SCORE_W +: SCORE_W]`.
- `fouls` out NUM_PLAYERS*FW: consecutive fouls, same packing.
- `shotTimer` out TW: frames elapsed in the current aim.

## Operation
- States: `IDLE`, `INIT`, `AIM`, `ROLL`, `RESPOT`, `TURN_END`, `GAME_OVER`.
- Outputs are Moore decodes of the registered state. `drawPortals` = `ROLL & hardMode`.
- **IDLE**
  - `idleState`=1.
  - `hardModeN`=0 → INIT with `hardMode`←1. Else `startN`=0 → INIT with `hardMode`←0.
  - On this transition: scores, fouls, `pocketed` (internal, width `$clog2(NUM_BALLS+1)`), `currentPlayer` and `winner` are cleared.
- **INIT**
  - One cycle; `init0`=`initPlayBalls`=1 → AIM.
- **AIM**
  - `drawSight`=`hitEnable`=1.
  - `startOfTurn`=1 only on the first AIM cycle after INIT or TURN_END; a player who continues after potting gets no pulse.
  - `shotTimer` is cleared on entry and increments on each `startOfFrame`.
  - Timer at `SHOT_FRAMES` with no `whiteBallMove` → TURN_END with foul.
  - `whiteBallMove` → ROLL; clears the per-shot flags `potted` and `scratch`. `whiteBallMove` has priority over a same-cycle timeout.
- **ROLL**, applied in priority order each cycle:
  - **Pot:** `playBallHoleCollision` adds 1 to `scores[currentPlayer]` (saturating at all-ones) and to `pocketed` (saturating at NUM_BALLS), and sets `potted`.
  - **Black:** `blackHoleCollision` → GAME_OVER. The shooter wins if `pocketed` (including a same-cycle pot) == NUM_BALLS and neither `whiteHoleCollision` this cycle nor `scratch` is set. Otherwise `winner` = (`currentPlayer`+1) mod NUM_PLAYERS.
  - **Scratch:** `whiteHoleCollision` sets sticky `scratch` and → RESPOT immediately.
  - **Rest:** `endOfRoll` with `potted` → AIM, same player. `endOfRoll` without `potted` → TURN_END, no foul.
- **RESPOT**
  - One cycle; `whiteBallin`=`init0`=1 → TURN_END with foul.
- **TURN_END**
  - One cycle.
  - With foul: `fouls[currentPlayer]`++. Reaching FOUL_LIMIT → GAME_OVER with `winner` = next player.
  - Without foul: `fouls[currentPlayer]`←0.
  - Otherwise `currentPlayer` advances, wrapping NUM_PLAYERS−1 → 0, → AIM.
- **GAME_OVER**
  - `gameOver`=1; `scores` and `winner` are held.
  - `startN` must be seen high at least once after entry (internal `released` flag). A subsequent `startN`=0 → IDLE.

## Timing
- `reset` is sampled at the `clk` edge and wins over every other input. After reset:
  - State IDLE, so `idleState`=1.
  - All other 1-bit outputs 0.
  - `hardMode`=0; `currentPlayer`, `winner`, `scores`, `fouls`, `shotTimer` all 0.
- An input event is registered at edge N; the new state and its strobes are visible from N+1.
- Counter updates land on the same edge as the state transition.
- INIT, RESPOT and TURN_END each last exactly 1 cycle.
- Pot to continued turn: AIM 1 cycle after `endOfRoll`.
- Foul to next player: scratch edge → RESPOT → TURN_END → AIM with the new `currentPlayer` and `startOfTurn`, 3 cycles.
- `startOfFrame` coinciding with the AIM entry cycle is not counted.
- Inputs other than `startN`/`hardModeN` are ignored in IDLE and GAME_OVER.
- `reset` mid-roll returns to IDLE on the next cycle, with no GAME_OVER.

## Test plan
- Reset, then `startN` low 1 cycle → INIT 1 cycle, AIM with `startOfTurn`=1, `currentPlayer`=0, `hardMode`=0.
- `hardModeN` low; strike; hold in ROLL → `drawPortals`=1. Pot 2 balls, then `endOfRoll` → `scores[0]`=2, player 0 back in AIM with no `startOfTurn`.
- Strike; `whiteHoleCollision` → `whiteBallin` for 1 cycle, `fouls[0]`=1, `currentPlayer`=1 three cycles later. Three consecutive fouls by one player → GAME_OVER with `winner` = other player.
- Hold AIM for 600 `startOfFrame` pulses → timeout foul; `currentPlayer` advances. A strike on frame 599 → ROLL, no foul.
- Pot 7 balls, then black alone → `winner`=shooter. Black with 6 pocketed, or together with the cue ball → `winner` = next player.
- GAME_OVER entered with `startN` held low stays there until `startN` goes high then low → IDLE. Mid-game `reset` → all outputs at reset values the next cycle.
